calc_port_arbiter: RTL and testbench

CALC_PORT_ARBITER -- requirements
Module: calc_port_arbiter

---
 rtl/calc_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_calc_port_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_port_arbiter.sv
// Four command-capture ports sharing one ALU through a round-robin arbiter.
// Define CALC_ARB_TIMEOUT_EN to bound the WAIT state to ALU_TIMEOUT cycles.
module calc_port_arbiter #(
  parameter int ALU_TIMEOUT = 16
) (
  input  logic        c_clk,
  input  logic        reset,

  input  logic [3:0]  req1_cmd_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [31:0] req2_data_in,
  input  logic [31:0] req3_data_in,
  input  logic [31:0] req4_data_in,

  output logic [1:0]  out_resp1,
  output logic [1:0]  out_resp2,
  output logic [1:0]  out_resp3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data1,
  output logic [31:0] out_data2,
  output logic [31:0] out_data3,
  output logic [31:0] out_data4,

  output logic        alu_valid,
  output logic [3:0]  alu_cmd,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  input  logic        alu_done,
  input  logic [1:0]  alu_resp,
  input  logic [31:0] alu_data
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StOp2     = 2'd1;
  localparam logic [1:0] StPending = 2'd2;
  localparam logic [1:0] StResp    = 2'd3;

  localparam logic [1:0] ArbIdle  = 2'd0;
  localparam logic [1:0] ArbIssue = 2'd1;
  localparam logic [1:0] ArbWait  = 2'd2;
  localparam logic [1:0] ArbDone  = 2'd3;

  localparam logic [1:0] RespOk    = 2'b01;
  localparam logic [1:0] RespError = 2'b11;

  if (ALU_TIMEOUT < 1) begin : g_bad_timeout
    $error("ALU_TIMEOUT must be at least 1");
  end

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return (cmd == 4'd1) || (cmd == 4'd2) || (cmd == 4'd5) || (cmd == 4'd6);
  endfunction

  logic [3:0]  cmd_in  [4];
  logic [31:0] data_in [4];

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  // Per-port capture state
  logic [1:0]  pst_q   [4];
  logic [1:0]  pst_d   [4];
  logic [3:0]  cmd_q   [4];
  logic [3:0]  cmd_d   [4];
  logic [31:0] op1_q   [4];
  logic [31:0] op1_d   [4];
  logic [31:0] op2_q   [4];
  logic [31:0] op2_d   [4];
  logic [1:0]  resp_q  [4];
  logic [1:0]  resp_d  [4];
  logic [31:0] rdata_q [4];
  logic [31:0] rdata_d [4];

  // Arbiter state
  logic [1:0]  arb_q, arb_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic [31:0] alu_op1_q, alu_op1_d;
  logic [31:0] alu_op2_q, alu_op2_d;
  logic [1:0]  res_resp_q, res_resp_d;
  logic [31:0] res_data_q, res_data_d;

  logic [3:0]  pend;
  logic        found;
  logic [1:0]  pick;
  logic        tmo_hit;

`ifdef CALC_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(ALU_TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = '0;
    if (arb_q == ArbWait) tmo_d = tmo_q + TmoW'(1);
  end

  // Last WAIT cycle of the budget without a completion forces an error.
  assign tmo_hit = (arb_q == ArbWait) && (tmo_q == TmoW'(ALU_TIMEOUT - 1));

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) pend[i] = (pst_q[i] == StPending);
  end

  // Round-robin search starting at the port after the last grant
  always_comb begin
    found = 1'b0;
    pick  = rr_q;
    for (int k = 0; k < 4; k++) begin
      if (!found && pend[rr_q + 2'(k)]) begin
        found = 1'b1;
        pick  = rr_q + 2'(k);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pst_d[i]   = pst_q[i];
      cmd_d[i]   = cmd_q[i];
      op1_d[i]   = op1_q[i];
      op2_d[i]   = op2_q[i];
      resp_d[i]  = resp_q[i];
      rdata_d[i] = rdata_q[i];
      case (pst_q[i])
        StIdle: begin
          if (cmd_in[i] != 4'd0) begin
            cmd_d[i] = cmd_in[i];
            op1_d[i] = data_in[i];
            pst_d[i] = StOp2;
          end
        end
        StOp2: begin
          op2_d[i] = data_in[i];
          if (cmd_supported(cmd_q[i])) begin
            pst_d[i] = StPending;
          end else begin
            resp_d[i]  = RespError;
            rdata_d[i] = 32'd0;
            pst_d[i]   = StResp;
          end
        end
        StPending: begin
          if ((arb_q == ArbDone) && (gnt_q == 2'(i))) begin
            resp_d[i]  = res_resp_q;
            rdata_d[i] = (res_resp_q == RespOk) ? res_data_q : 32'd0;
            pst_d[i]   = StResp;
          end
        end
        StResp:  pst_d[i] = StIdle;
        default: pst_d[i] = StIdle;
      endcase
    end
  end

  always_comb begin
    arb_d      = arb_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    alu_cmd_d  = alu_cmd_q;
    alu_op1_d  = alu_op1_q;
    alu_op2_d  = alu_op2_q;
    res_resp_d = res_resp_q;
    res_data_d = res_data_q;
    case (arb_q)
      ArbIdle: begin
        if (found) begin
          gnt_d     = pick;
          rr_d      = pick + 2'd1;
          alu_cmd_d = cmd_q[pick];
          alu_op1_d = op1_q[pick];
          alu_op2_d = op2_q[pick];
          arb_d     = ArbIssue;
        end
      end
      ArbIssue: arb_d = ArbWait;
      ArbWait: begin
        if (alu_done) begin
          res_resp_d = alu_resp;
          res_data_d = alu_data;
          arb_d      = ArbDone;
        end else if (tmo_hit) begin
          res_resp_d = RespError;
          res_data_d = 32'd0;
          arb_d      = ArbDone;
        end
      end
      ArbDone: begin
        alu_cmd_d = 4'd0;
        alu_op1_d = 32'd0;
        alu_op2_d = 32'd0;
        arb_d     = ArbIdle;
      end
      default: arb_d = ArbIdle;
    endcase
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        pst_q[i]   <= StIdle;
        cmd_q[i]   <= 4'd0;
        op1_q[i]   <= 32'd0;
        op2_q[i]   <= 32'd0;
        resp_q[i]  <= 2'd0;
        rdata_q[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        pst_q[i]   <= pst_d[i];
        cmd_q[i]   <= cmd_d[i];
        op1_q[i]   <= op1_d[i];
        op2_q[i]   <= op2_d[i];
        resp_q[i]  <= resp_d[i];
        rdata_q[i] <= rdata_d[i];
      end
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      arb_q      <= ArbIdle;
      gnt_q      <= 2'd0;
      rr_q       <= 2'd0;
      alu_cmd_q  <= 4'd0;
      alu_op1_q  <= 32'd0;
      alu_op2_q  <= 32'd0;
      res_resp_q <= 2'd0;
      res_data_q <= 32'd0;
    end else begin
      arb_q      <= arb_d;
      gnt_q      <= gnt_d;
      rr_q       <= rr_d;
      alu_cmd_q  <= alu_cmd_d;
      alu_op1_q  <= alu_op1_d;
      alu_op2_q  <= alu_op2_d;
      res_resp_q <= res_resp_d;
      res_data_q <= res_data_d;
    end
  end

  logic [1:0]  resp_out [4];
  logic [31:0] data_out [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      resp_out[i] = (pst_q[i] == StResp) ? resp_q[i]  : 2'd0;
      data_out[i] = (pst_q[i] == StResp) ? rdata_q[i] : 32'd0;
    end
  end

  assign out_resp1 = resp_out[0];
  assign out_resp2 = resp_out[1];
  assign out_resp3 = resp_out[2];
  assign out_resp4 = resp_out[3];
  assign out_data1 = data_out[0];
  assign out_data2 = data_out[1];
  assign out_data3 = data_out[2];
  assign out_data4 = data_out[3];

  assign alu_valid = (arb_q == ArbIssue);
  assign alu_cmd   = alu_cmd_q;
  assign alu_op1   = alu_op1_q;
  assign alu_op2   = alu_op2_q;

endmodule

// File: tb/tb_calc_port_arbiter.sv
// Scoreboard bench for calc_port_arbiter: drivers push expected responses, a negedge
// monitor pops and compares port responses and ALU issues against a round-robin model.
module tb_calc_port_arbiter;
  localparam int AluTimeout = 16;

  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req_cmd  [4];
  logic [31:0] req_data [4];
  logic [1:0]  out_resp [4];
  logic [31:0] out_data [4];
  logic        alu_valid;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_op1, alu_op2;
  logic        alu_done;
  logic [1:0]  alu_resp;
  logic [31:0] alu_data;

  calc_port_arbiter #(.ALU_TIMEOUT(AluTimeout)) dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(req_cmd[0]), .req2_cmd_in(req_cmd[1]),
    .req3_cmd_in(req_cmd[2]), .req4_cmd_in(req_cmd[3]),
    .req1_data_in(req_data[0]), .req2_data_in(req_data[1]),
    .req3_data_in(req_data[2]), .req4_data_in(req_data[3]),
    .out_resp1(out_resp[0]), .out_resp2(out_resp[1]),
    .out_resp3(out_resp[2]), .out_resp4(out_resp[3]),
    .out_data1(out_data[0]), .out_data2(out_data[1]),
    .out_data3(out_data[2]), .out_data4(out_data[3]),
    .alu_valid(alu_valid), .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_done(alu_done), .alu_resp(alu_resp), .alu_data(alu_data)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          port;
    logic [1:0]  resp;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  // Port-side model
  int          phase    [4];
  bit          seen     [4];
  bit          pending  [4];
  int          pend_cyc [4];
  logic [3:0]  st_cmd   [4];
  logic [31:0] st_op1   [4];
  logic [31:0] st_op2   [4];
  bit          want_v   [4];
  logic [3:0]  want_cmd [4];
  logic [31:0] want_op1 [4];
  logic [31:0] want_op2 [4];
  bit          rand_en = 1'b0;
  int          resp_count = 0;

  // ALU-side model
  bit          f_v = 1'b0;
  bit          f_nodone;
  int          f_lat;
  logic [1:0]  f_resp;
  logic [31:0] f_data;
  bit          outstanding = 1'b0;
  bit          o_nodone;
  int          o_port;
  int          done_cyc;
  logic [3:0]  o_cmd;
  logic [31:0] o_op1, o_op2, o_data;
  logic [1:0]  o_resp;
  int          last_gnt = 3;
  int          grant_log[$];

  function automatic bit is_valid(input logic [3:0] c);
    return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
  endfunction

  function automatic logic [3:0] rand_cmd();
    logic [3:0] c;
    case ($urandom_range(0, 4))
      0: c = 4'd1;
      1: c = 4'd2;
      2: c = 4'd5;
      3: c = 4'd6;
      default: c = 4'($urandom_range(1, 15));
    endcase
    return c;
  endfunction

  task automatic push_exp(input int p, input logic [1:0] r, input logic [31:0] d, input int c);
    exp_t e;
    e.port = p;
    e.resp = r;
    e.data = d;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic drive_cycle();
    logic [1:0] r;
    for (int p = 0; p < 4; p++) begin
      if (phase[p] == 2 && seen[p]) phase[p] = 0;
      case (phase[p])
        0: begin
          if (want_v[p] || (rand_en && $urandom_range(0, 2) == 0)) begin
            st_cmd[p] = want_v[p] ? want_cmd[p] : rand_cmd();
            st_op1[p] = want_v[p] ? want_op1[p] : $urandom;
            st_op2[p] = want_v[p] ? want_op2[p] : $urandom;
            want_v[p] = 1'b0;
            req_cmd[p] = st_cmd[p];
            req_data[p] = st_op1[p];
            phase[p] = 1;
          end else begin
            req_cmd[p] = 4'd0;
            req_data[p] = $urandom;
          end
        end
        1: begin
          req_data[p] = st_op2[p];
          req_cmd[p] = 4'($urandom_range(0, 15));
          seen[p] = 1'b0;
          if (is_valid(st_cmd[p])) begin
            pending[p] = 1'b1;
            pend_cyc[p] = cyc + 1;
          end else begin
            push_exp(p, 2'b11, 32'd0, cyc + 1);
          end
          phase[p] = 2;
        end
        default: begin
          req_cmd[p] = 4'($urandom_range(0, 15));
          req_data[p] = $urandom;
        end
      endcase
    end
    alu_done = 1'b0;
    alu_resp = 2'($urandom);
    alu_data = $urandom;
    if (outstanding && cyc == done_cyc) begin
      r = o_nodone ? 2'b11 : o_resp;
      if (!o_nodone) begin
        alu_done = 1'b1;
        alu_resp = o_resp;
        alu_data = o_data;
      end
      push_exp(o_port, r, (r == 2'b01) ? o_data : 32'd0, cyc + 2);
      outstanding = 1'b0;
    end else if (!outstanding && $urandom_range(0, 7) == 0) begin
      alu_done = 1'b1;
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #1;
      drive_cycle();
    end
  endtask

  function automatic bit model_idle();
    for (int p = 0; p < 4; p++) begin
      if (phase[p] == 1 || pending[p] || want_v[p] || (phase[p] == 2 && !seen[p])) return 1'b0;
    end
    return !outstanding && (sbq.size() == 0);
  endfunction

  task automatic drain();
    int n = 0;
    while (!model_idle() && n < 2000) begin
      run(1);
      n++;
    end
    chk(model_idle(), "drain_timeout", n, 0);
  endtask

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      phase[p] = 0;
      pending[p] = 1'b0;
      want_v[p] = 1'b0;
      seen[p] = 1'b0;
    end
    outstanding = 1'b0;
    f_v = 1'b0;
    sbq.delete();
    last_gnt = 3;
  endtask

  task automatic want(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b);
    want_v[p] = 1'b1;
    want_cmd[p] = c;
    want_op1[p] = a;
    want_op2[p] = b;
  endtask

  task automatic force_alu(input int lat, input logic [1:0] r, input logic [31:0] d,
                           input bit nodone);
    f_v = 1'b1;
    f_lat = lat;
    f_resp = r;
    f_data = d;
    f_nodone = nodone;
  endtask

  task automatic check_all_zero(input string tag);
    chk(alu_valid == 1'b0, {tag, "_alu_valid"}, alu_valid, 0);
    chk({alu_cmd, alu_op1, alu_op2} == 68'd0, {tag, "_alu_bus"}, alu_op1, 0);
    for (int p = 0; p < 4; p++) begin
      chk(out_resp[p] == 2'd0 && out_data[p] == 32'd0, {tag, "_port_out"}, out_resp[p], 0);
    end
  endtask

  // Monitor: port responses and ALU issues
  always @(negedge c_clk) begin
    int g;
    int idx;
    int lat;
    if (!reset) begin
      for (int p = 0; p < 4; p++) begin
        if (out_resp[p] != 2'b00) begin
          resp_count++;
          idx = -1;
          for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].port == p) idx = i;
          if (idx < 0) begin
            chk(1'b0, "unexpected_resp", out_resp[p], 0);
          end else begin
            chk(out_resp[p] == sbq[idx].resp, "resp_code", out_resp[p], sbq[idx].resp);
            chk(out_data[p] == sbq[idx].data, "resp_data", out_data[p], sbq[idx].data);
            chk(cyc == sbq[idx].cyc, "resp_cycle", cyc, sbq[idx].cyc);
            sbq.delete(idx);
            seen[p] = 1'b1;
          end
        end else begin
          chk(out_data[p] == 32'd0, "data_without_resp", out_data[p], 0);
        end
      end
      if (alu_valid) begin
        chk(!outstanding, "alu_valid_while_busy", 1, 0);
        g = -1;
        for (int k = 1; k <= 4; k++) begin
          idx = (last_gnt + k) % 4;
          if (g < 0 && pending[idx] && pend_cyc[idx] <= cyc - 1) g = idx;
        end
        if (g < 0) begin
          chk(1'b0, "alu_valid_no_pending", alu_cmd, 0);
        end else begin
          chk(alu_cmd == st_cmd[g], "issue_cmd", alu_cmd, st_cmd[g]);
          chk(alu_op1 == st_op1[g], "issue_op1", alu_op1, st_op1[g]);
          chk(alu_op2 == st_op2[g], "issue_op2", alu_op2, st_op2[g]);
          pending[g] = 1'b0;
          last_gnt = g;
          grant_log.push_back(g);
          outstanding = 1'b1;
          o_port = g;
          o_cmd = st_cmd[g];
          o_op1 = st_op1[g];
          o_op2 = st_op2[g];
          if (f_v) begin
            lat = f_lat;
            o_resp = f_resp;
            o_data = f_data;
            o_nodone = f_nodone;
            f_v = 1'b0;
          end else begin
            lat = $urandom_range(1, 6);
            o_resp = 2'($urandom_range(1, 3));
            o_data = $urandom;
            o_nodone = 1'b0;
          end
          done_cyc = o_nodone ? cyc + AluTimeout : cyc + lat;
        end
      end else if (outstanding) begin
        chk({alu_cmd, alu_op1, alu_op2} == {o_cmd, o_op1, o_op2}, "alu_hold", alu_op1, o_op1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rc;
    for (int p = 0; p < 4; p++) begin
      req_cmd[p] = 4'd0;
      req_data[p] = 32'd0;
    end
    model_reset();
    alu_done = 1'b0;
    alu_resp = 2'd0;
    alu_data = 32'd0;
    repeat (3) @(posedge c_clk);
    @(negedge c_clk);
    check_all_zero("reset_state");
    @(posedge c_clk);
    #1;
    reset = 1'b0;

    // All four ports at once from a fresh pointer
    grant_log.delete();
    for (int p = 0; p < 4; p++) want(p, 4'd2, $urandom, $urandom);
    drain();
    chk(grant_log.size() == 4, "rr_grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk(grant_log[i] == i, "rr_order", grant_log[i], i);

    want(0, 4'd1, 32'h64, 32'h27);
    force_alu(1, 2'b01, 32'h8B, 1'b0);
    drain();

    grant_log.delete();
    want(1, 4'h9, 32'h1111, 32'h2222);
    drain();
    chk(grant_log.size() == 0, "invalid_not_issued", grant_log.size(), 0);

    want(2, 4'd1, 32'hFFFF_FFFF, 32'h1);
    force_alu(2, 2'b10, 32'h1234, 1'b0);
    drain();

`ifdef CALC_ARB_TIMEOUT_EN
    want(3, 4'd5, 32'hA5, 32'h5A);
    force_alu(0, 2'b01, 32'h0, 1'b1);
    drain();
`endif

    rand_en = 1'b1;
    run(3000);
    rand_en = 1'b0;
    drain();

    // Reset while the arbiter waits on the ALU
    want(0, 4'd1, 32'd5, 32'd6);
    force_alu(40, 2'b01, 32'd77, 1'b0);
    n = 0;
    while (!outstanding && n < 50) begin
      run(1);
      n++;
    end
    chk(outstanding, "issue_before_reset", n, 0);
    run(2);
    chk(alu_cmd == 4'd1, "hold_before_reset", alu_cmd, 1);
    @(posedge c_clk);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    model_reset();
    repeat (2) @(posedge c_clk);
    #1;
    reset = 1'b0;
    alu_done = 1'b0;
    for (int p = 0; p < 4; p++) req_cmd[p] = 4'd0;
    rc = resp_count;
    @(posedge c_clk);
    #1;
    alu_done = 1'b1;
    alu_resp = 2'b01;
    alu_data = 32'd77;
    run(10);
    chk(resp_count == rc, "no_resp_after_reset", resp_count - rc, 0);
    chk(sbq.size() == 0, "scoreboard_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
